ins_fetch_unit: RTL
===================

# ins_fetch_unit

Instruction fetch stage placed directly upstream of the single-cycle ARM core. It replaces the core's direct combinational instruction-memory lookup. It issues in-order word requests to a latency-tolerant instruction memory and buffers the returned words with their PCs in a DEPTH-entry queue. It hands one instruction per cycle to the core over a valid/ready handshake, and flushes on a branch redirect from the core.

## Interface

**Parameters**
- DEPTH, 4: queue entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset. Word aligned.

**Ports**
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid. Responses arrive in request order with no backpressure; latency is ≥1 cycle.
- imem_rsp_data  in  32  response instruction word.
- redirect  in  1  branch/PC-write flush from the core.
- redirect_pc  in  32  new fetch address. Bits [1:0] are ignored and treated as 0.
- ins_valid  out  1  instruction available to the core.
- ins_ready  in  1  core consumes instruction.
- ins_data  out  32  instruction word.
- ins_pc  out  32  PC of ins_data.
- ins_pc_add_4  out  32  ins_pc + 4.
- fetch_count  out  32  only with IFU_PERF_CNT_EN.
- starve_count  out  32  only with IFU_PERF_CNT_EN.

## Operation

**Registers**
- fetch_pc: next request address.
- rsp_pc: PC of the next response.
- outstanding: accepted requests whose response has not yet arrived. Width $clog2(DEPTH)+1.
- drop: number of responses still to be discarded.
- Queue: entries of {pc, data}.

**Credit rule.** A request may be issued only when occupancy + outstanding < DEPTH. As a result, a response can never find the queue full.

**Request**
- imem_req_valid = credit && !redirect && state != IDLE.
- imem_req_addr = fetch_pc.
- While valid is high and ready is low, imem_req_addr stays stable.
- redirect is the only event allowed to withdraw valid.
- On accept (valid && ready): fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.

**Response**
- Every response decrements outstanding.
- If drop > 0: the word is discarded and drop decrements.
- Otherwise: {rsp_pc, data} is pushed to the queue and rsp_pc += 4.

**Pop.** When ins_valid && ins_ready, the head entry is removed.

**Redirect (in cycle N)**
- The queue is emptied.
- fetch_pc and rsp_pc are set to {redirect_pc[31:2], 2'b00}.
- drop is set to outstanding minus any response arriving in cycle N. That response itself is discarded.
- A pop in cycle N still completes, because the core has already consumed that instruction. Redirect overrides everything else.

**FSM**
- IDLE: the reset state. Goes to FETCH on the first clock after rst deasserts.
- FETCH: goes to FLUSH when redirect occurs with a nonzero drop result.
- FLUSH: goes to FETCH when drop reaches 0 with no new redirect. A redirect while in FLUSH recomputes drop.
- Requests are allowed in both FETCH and FLUSH. In-flight drops still consume credit.

## Timing

**Reset values.** While rst = 0, every output is forced:
- imem_req_valid = 0, imem_req_addr = RESET_PC.
- ins_valid = 0, ins_data = 0, ins_pc = 0, ins_pc_add_4 = 4.
- Counters = 0, outstanding = 0, drop = 0, queue empty.

**Reset mid-operation.** Asserting rst at any time, including with requests in flight, forces the reset values above. Responses to requests issued before reset must not arrive after rst deasserts; the memory guarantees this by sharing the same reset.

**Latencies**
- The first request (addr = RESET_PC) is issued 1 cycle after reset deassertion.
- A response in cycle N appears on ins_valid/ins_data/ins_pc in cycle N+1, with registered outputs driven from the queue head.
- Redirect in cycle N: ins_valid = 0 in cycle N+1. The first request at redirect_pc is issued in cycle N+1.
- With 1-cycle memory latency and ins_ready held high, throughput is 1 instruction per cycle.

## Configuration

**IFU_PERF_CNT_EN**
- Defined:
  - fetch_count increments on every accepted request.
  - starve_count increments every cycle in FETCH/FLUSH where ins_valid = 0.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure

- Package arm_fetch_pkg: ADDR_W = 32, INSN_W = 32, the fetch_state_e enum {IDLE, FETCH, FLUSH}, and the struct fetch_entry_t {pc, data}.
- Sub-module fetch_fifo holds the DEPTH-entry synchronous queue, with push/pop/flush and full/empty/count outputs. Flush has priority over push.

## Test plan

- **Reset and stream.** Release rst; memory has 1-cycle latency, always ready; ins_ready = 1.
  - Requests 0x0, 0x4, 0x8 are issued on consecutive cycles.
  - ins_pc is 0x0, 0x4, 0x8 on consecutive cycles, with ins_pc_add_4 = ins_pc + 4.
- **Backpressure.** ins_ready = 0 with DEPTH = 4.
  - Exactly 4 requests are accepted, then imem_req_valid stays 0.
  - When ins_ready = 1, the queue drains in order 0x0 through 0xC.
- **Memory stall.** imem_req_ready = 0 for 3 cycles.
  - imem_req_addr stays 0x10 throughout and valid stays 1.
  - The request is accepted on the cycle ready rises.
- **Redirect with in-flight responses.** 2 requests outstanding (latency 3) when redirect occurs with redirect_pc = 0x100.
  - Both late responses are dropped.
  - The next delivered instruction has ins_pc = 0x100.
  - The FSM returns to FETCH.
- **Redirect on the same cycle as a response and a pop.**
  - The response word is discarded and the pop completes.
  - ins_valid = 0 next cycle.
  - redirect_pc = 0x203 fetches 0x200.
- **Wrap and counters.** Redirect to 0xFFFF_FFFC.
  - Next fetch is 0x0000_0000.
  - With IFU_PERF_CNT_EN, fetch_count equals the number of accepted requests and starve_count equals the number of empty cycles.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_fetch_pkg
// Purpose  : Shared widths, FSM states and queue entry type for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package arm_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INSN_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] data;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous queue of {pc, data}; flush beats push.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/ins_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetch_unit
// Purpose  : Credit-based in-order instruction fetch with redirect flush.
//            Optional perf counters: define IFU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INSN_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [ADDR_W-1:0] ins_pc_add_4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       starve_count
`endif
);

  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_LIM  = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;

  logic              credit, accept, pop;
  logic [CNT_W:0]    inflight;

  // Dropped responses still hold credit until they arrive.
  assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit         = (inflight < DEPTH_LIM);
  assign imem_req_valid = credit && !redirect && (state_q != IDLE);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pop            = ins_valid && ins_ready;
  assign push_entry     = '{pc: rsp_pc_q, data: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    if (accept) begin
      fetch_pc_d = fetch_pc_q + WORD_STEP;
    end
    if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end else begin
        fifo_push = !fifo_full;
        rsp_pc_d  = rsp_pc_q + WORD_STEP;
      end
    end
    // Any response landing with the redirect belongs to the old stream.
    if (redirect) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      rsp_pc_d   = redirect_pc & ALIGN_MASK;
      drop_d     = outstanding_q - CNT_W'(imem_rsp_valid);
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (drop_d != '0) ? FLUSH : FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   state_d = FETCH;
        FLUSH:   state_d = (drop_d == '0) ? FETCH : FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs read zero whenever no instruction is held, including in reset.
  assign ins_valid    = !fifo_empty;
  assign ins_data     = ins_valid ? fifo_head.data : '0;
  assign ins_pc       = ins_valid ? fifo_head.pc : '0;
  assign ins_pc_add_4 = ins_pc + WORD_STEP;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] starve_count_q, starve_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    starve_count_d = starve_count_q;
    if (accept && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if ((state_q != IDLE) && !ins_valid && (starve_count_q != '1)) begin
      starve_count_d = starve_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q  <= '0;
      starve_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      starve_count_q <= starve_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign starve_count = starve_count_q;
`else
  // No performance counters in this build.
`endif

endmodule
`default_nettype wire
